// File: rtl/ahb_s2m_s2.sv
// ahb_s2m_s2: AHB-Lite 2-slave response mux with built-in default slave (two-cycle ERROR).
// Optional saturating default-slave error counter under AHB_S2M_ERRCNT_EN.
module ahb_s2m_s2 #(
  parameter int P_DW    = 32,
  parameter int P_CNT_W = 8
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic               HSELd,
  input  logic               HSEL0,
  input  logic               HSEL1,
  input  logic [1:0]         HTRANS,
  input  logic               HREADYOUT0,
  input  logic               HRESP0,
  input  logic [P_DW-1:0]    HRDATA0,
  input  logic               HREADYOUT1,
  input  logic               HRESP1,
  input  logic [P_DW-1:0]    HRDATA1,
  output logic               HREADY,
  output logic               HRESP,
  output logic [P_DW-1:0]    HRDATA,
  output logic [P_CNT_W-1:0] ERR_CNT
);
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_t;
  ds_t ds_q, ds_d;
  logic [2:0] sel_q;
  logic ds_ready, ds_resp, acc;
  logic unused_htrans0;
  assign unused_htrans0 = HTRANS[0];
  always_comb begin
    ds_ready = ds_q != DS_ERR1;
    ds_resp  = ds_q != DS_IDLE;
    HREADY   = sel_q[0] ? HREADYOUT0 : sel_q[1] ? HREADYOUT1 : ds_ready;
    HRESP    = sel_q[0] ? HRESP0 : sel_q[1] ? HRESP1 : ds_resp;
    HRDATA   = sel_q[0] ? HRDATA0 : sel_q[1] ? HRDATA1 : '0;
    acc      = HSELd & HREADY & HTRANS[1];
    ds_d     = (ds_q == DS_ERR1) ? DS_ERR2 : acc ? DS_ERR1 : DS_IDLE;
  end
  // selection only advances when the current data phase completes
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      sel_q <= 3'b100;
      ds_q  <= DS_IDLE;
    end else begin
      ds_q <= ds_d;
      if (HREADY) sel_q <= HSEL0 ? 3'b001 : HSEL1 ? 3'b010 : 3'b100;
    end
`ifdef AHB_S2M_ERRCNT_EN
  logic [P_CNT_W-1:0] cnt_q;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) cnt_q <= '0;
    else if (ds_d == DS_ERR1 && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  assign ERR_CNT = cnt_q;
`else
  assign ERR_CNT = '0;
`endif
endmodule
